// File: rtl/dmg_link_peer_if.sv
// User-side byte interface of the DMG link peer: tx byte in, rx byte out.
// Latency: none, wires only.
// Backpressure: tx_ready gates tx_valid; rx_valid is a one-cycle pulse with no ready.
interface dmg_link_peer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  // user / bench side
  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  // peer side
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/dmg_link_peer.sv
// Far end of the DMG serial cable: shifts a byte out on SI while shifting SO in; SCK slave or master.
// Latency: rx_valid pulses one clk after the synchronized 8th SCK rise; SCK edges seen SYNC_STAGES clk late.
// Backpressure: tx_ready low from byte load until its transfer completes. Option macro: DMG_LINK_PEER_ECHO_EN.
module dmg_link_peer #(
  parameter int CLK_DIV     = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             master,
  dmg_link_peer_if.slave   lnk,
  input  logic             sck_in,
  output logic             sck_out,
  output logic             sck_oe,
  input  logic             sd_in,
  output logic             sd_out,
  output logic             busy
);

  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync, sd_sync;
  logic                   sck_src, sck_prev, sck_rise, sck_fall, sd_s;
  logic [7:0]             tx_sr, rx_sr, rx_data_q;
  logic [3:0]             bit_cnt;
  logic                   rose;      // a rise has been seen since the last tx shift
  logic                   loaded;    // tx_sr holds a byte that has not been sent yet
  logic                   mst_q;     // mode latched at transfer start
  logic                   sck_gen;   // internally divided SCK for master mode
  logic [DW-1:0]          div_cnt;
  logic                   accept, done_ready;

`ifdef DMG_LINK_PEER_ECHO_EN
  logic                   echo_pend; // tx_sr holds an echoed byte
  // Echo alternates: a received byte is echoed once, and the byte that completes
  // the echo is not itself echoed, so the user side gets its turn again.
  assign done_ready = echo_pend;
`else
  assign done_ready = 1'b1;
`endif

  // In master mode the divided clock replaces the pad in the edge path.
  assign sck_src  = mst_q ? sck_gen : sck_sync[SYNC_STAGES-1];
  assign sd_s     = sd_sync[SYNC_STAGES-1];
  assign sck_rise = sck_src & ~sck_prev;
  assign sck_fall = ~sck_src & sck_prev;

  assign lnk.tx_ready = ((state_q == IDLE) && !loaded) || ((state_q == DONE) && done_ready);
  assign accept       = lnk.tx_valid & lnk.tx_ready;
  assign lnk.rx_data  = rx_data_q;
  assign sd_out       = tx_sr[7];
  assign sck_out      = sck_gen;

  // Pad synchronizers; idle-high line so they reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= '1;
      sd_sync  <= '1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd_in};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and status outputs.
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    sck_oe       = 1'b0;
    lnk.rx_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // sck_in is ignored while master is selected
        if (master) begin
          if (accept || loaded) state_d = SHIFT;
        end else if (sck_fall) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        sck_oe = mst_q;
        if (sck_rise && (bit_cnt == 4'd7)) state_d = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        lnk.rx_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift registers, bit counter, SCK divider and tx byte bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_prev  <= 1'b1;
      tx_sr     <= 8'hFF;
      rx_sr     <= 8'h00;
      rx_data_q <= 8'hFF;
      bit_cnt   <= 4'd0;
      rose      <= 1'b0;
      loaded    <= 1'b0;
      mst_q     <= 1'b0;
      sck_gen   <= 1'b1;
      div_cnt   <= '0;
`ifdef DMG_LINK_PEER_ECHO_EN
      echo_pend <= 1'b0;
`endif
    end else begin
      sck_prev <= sck_src;
      case (state_q)
        IDLE: begin
          bit_cnt <= 4'd0;
          rose    <= 1'b0;
          if (accept) begin
            tx_sr  <= lnk.tx_data;
            loaded <= 1'b1;
          end
          // master start: first SCK edge is the fall right here
          if (master && (accept || loaded)) begin
            mst_q   <= 1'b1;
            sck_gen <= 1'b0;
            div_cnt <= '0;
          end
        end
        SHIFT: begin
          if (mst_q) begin
            if (div_cnt == DW'(CLK_DIV - 1)) begin
              div_cnt <= '0;
              sck_gen <= ~sck_gen;
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
          if (sck_rise) begin
            rx_sr   <= {rx_sr[6:0], sd_s};
            bit_cnt <= bit_cnt + 4'd1;
            rose    <= 1'b1;
            if (bit_cnt == 4'd7) rx_data_q <= {rx_sr[6:0], sd_s};
          end else if (sck_fall && rose) begin
            // the transfer-opening fall does not shift: MSB is already on sd_out
            tx_sr <= {tx_sr[6:0], 1'b1};
            rose  <= 1'b0;
          end
        end
        DONE: begin
          mst_q   <= 1'b0;
          sck_gen <= 1'b1;
          div_cnt <= '0;
          tx_sr   <= 8'hFF;
          loaded  <= 1'b0;
`ifdef DMG_LINK_PEER_ECHO_EN
          if (!echo_pend) begin
            tx_sr     <= rx_data_q;
            loaded    <= 1'b1;
            echo_pend <= 1'b1;
          end else begin
            echo_pend <= 1'b0;
          end
`endif
          // accept only possible when done_ready, so it never collides with an echo load
          if (accept) begin
            tx_sr  <= lnk.tx_data;
            loaded <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmg_link_peer.sv
module tb_dmg_link_peer;

  localparam int CLK_DIV = 4;
  localparam int H       = 16;   // DMG-driven SCK half-period in clk
`ifdef DMG_LINK_PEER_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, master, sck_in, sck_out, sck_oe, sd_in, sd_out, busy;

  dmg_link_peer_if lnk();

  dmg_link_peer #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .master(master), .lnk(lnk),
    .sck_in(sck_in), .sck_out(sck_out), .sck_oe(sck_oe),
    .sd_in(sd_in), .sd_out(sd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: what the peer will send next, and echo state
  logic [7:0] pend;
  bit         pend_vld  = 0;
  bit         echo_pend = 0;

  // scoreboard queues
  logic [7:0] exp_rx[$];
  logic [7:0] exp_sd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transfer completion in model terms: the byte just sent is consumed
  task automatic model_complete(input logic [7:0] d);
    if (ECHO && !echo_pend) begin
      pend = d; pend_vld = 1; echo_pend = 1;
    end else begin
      pend_vld = 0; echo_pend = 0;
    end
  endtask

  // rx monitor
  always @(negedge clk) begin
    if (!reset && lnk.rx_valid) begin
      if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
      else check("rx_data", lnk.rx_data, exp_rx.pop_front());
    end
  end

  // sd_out monitor: DMG samples SI on each rise of the SCK line
  logic       mon_prev = 1'b1;
  int         mon_cnt  = 0;
  logic [7:0] mon_acc  = 8'h00;
  always @(negedge clk) begin
    logic line;
    line = sck_oe ? sck_out : sck_in;
    if (reset) begin
      mon_cnt = 0;
      mon_prev = 1'b1;
    end else begin
      if (line && !mon_prev) begin
        mon_acc = {mon_acc[6:0], sd_out};
        mon_cnt++;
        if (mon_cnt == 8) begin
          mon_cnt = 0;
          if (exp_sd.size() == 0) check("sd_unexpected", 1, 0);
          else check("sd_byte", mon_acc, exp_sd.pop_front());
        end
      end
      mon_prev = line;
    end
  end

  task automatic check_reset_vals();
    check("rst_tx_ready", lnk.tx_ready, 1);
    check("rst_rx_data",  lnk.rx_data, 8'hFF);
    check("rst_rx_valid", lnk.rx_valid, 0);
    check("rst_sck_out",  sck_out, 1);
    check("rst_sck_oe",   sck_oe, 0);
    check("rst_sd_out",   sd_out, 1);
    check("rst_busy",     busy, 0);
  endtask

  task automatic offer(input logic [7:0] b, input int maxc, output bit acc, output bit in_done);
    acc = 0; in_done = 0;
    lnk.tx_data = b; lnk.tx_valid = 1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (lnk.tx_ready) begin
        in_done = lnk.rx_valid;
        acc = 1;
        break;
      end
    end
    if (acc) begin
      @(posedge clk); #1;
      pend = b; pend_vld = 1;
    end
    lnk.tx_valid = 0;
    if (!acc) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input logic [7:0] d);
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (lnk.rx_valid) seen = 1;
    end
    check("rx_valid_seen", seen, 1);
    if (seen) model_complete(d);
  endtask

  // DMG as clock master, sending d
  task automatic slave_xfer(input logic [7:0] d);
    exp_sd.push_back(pend_vld ? pend : 8'hFF);
    exp_rx.push_back(d);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sck_in = 0; sd_in = d[7-i];
      repeat (H) @(posedge clk);
      #1 sck_in = 1;
      if (i < 7) repeat (H - 1) @(posedge clk);
    end
    wait_done(d);
    repeat (H) @(posedge clk);
    #1;
  endtask

  // peer as clock master sending b, DMG answering d
  task automatic master_xfer(input logic [7:0] b, input logic [7:0] d);
    bit acc, ind;
    int lo, hi, t;
    master = 1;
    offer(b, 8, acc, ind);
    master = 0;
    check("mst_accept", acc, 1);
    if (acc) begin
      exp_sd.push_back(b);
      exp_rx.push_back(d);
      t = 0;
      do begin @(negedge clk); t++; end while (!(sck_oe && !sck_out) && t < 100);
      check("mst_first_fall", sck_oe && !sck_out, 1);
      for (int i = 0; i < 8; i++) begin
        sd_in = d[7-i];
        lo = 1;
        forever begin
          @(negedge clk);
          if (sck_out || lo >= 100) break;
          lo++;
        end
        check("mst_low_len", lo, CLK_DIV);
        check("mst_oe_high", sck_oe, 1);
        if (i < 7) begin
          hi = 1;
          forever begin
            @(negedge clk);
            if (!sck_out || hi >= 100) break;
            hi++;
          end
          check("mst_high_len", hi, CLK_DIV);
        end
      end
      wait_done(d);
      @(negedge clk);
      check("mst_oe_after", sck_oe, 0);
      check("mst_sck_after", sck_out, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bit acc, ind, exp_acc, mst;
    logic [7:0] b, d;

    reset = 1; master = 0; sck_in = 1; sd_in = 1;
    lnk.tx_valid = 0; lnk.tx_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (4) @(posedge clk);
    #1;

    // slave exchange
    offer(8'hA5, 4, acc, ind);
    check("a5_accept", acc, 1);
    slave_xfer(8'h3C);
    @(negedge clk);
    check("a5_tx_ready_after", lnk.tx_ready, !pend_vld);
    @(posedge clk); #1;

    // nothing loaded
    slave_xfer(8'h00);

    // master mode
    if (pend_vld) slave_xfer(8'h5A);
    master_xfer(8'h81, 8'hFE);

    // handshake: tx_valid held during SHIFT
    if (pend_vld) slave_xfer(8'h11);
    exp_acc = !ECHO || echo_pend;
    fork
      slave_xfer(8'hC3);
      begin
        int t = 0;
        while (!busy && t < 200) begin @(negedge clk); t++; end
        check("hs_busy_seen", busy, 1);
        @(posedge clk); #1;
        offer(8'h55, 600, acc, ind);
      end
    join
    check("hs_accept", acc, exp_acc);
    if (acc) check("hs_accept_in_done", ind, 1);
    slave_xfer(8'h96);

`ifdef DMG_LINK_PEER_ECHO_EN
    if (pend_vld) slave_xfer(8'h22);
    slave_xfer(8'h42);
    @(negedge clk);
    check("echo_tx_ready", lnk.tx_ready, 0);
    @(posedge clk); #1;
    offer(8'h99, 10, acc, ind);
    check("echo_ignore_99", acc, 0);
    slave_xfer(8'h7E);
`endif

    // randomized transfers
    for (int it = 0; it < 12; it++) begin
      b = 8'($urandom);
      d = 8'($urandom);
      mst = ($urandom_range(0, 1) == 1) && !pend_vld;
      @(negedge clk);
      check("idle_tx_ready", lnk.tx_ready, !pend_vld);
      @(posedge clk); #1;
      if (mst) begin
        master_xfer(b, d);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          exp_acc = !pend_vld;
          offer(b, 4, acc, ind);
          check("rand_accept", acc, exp_acc);
        end
        slave_xfer(d);
      end
    end

    // reset during a shift, after 4 rises
    if (!pend_vld) offer(8'h0F, 4, acc, ind);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      sck_in = 0; sd_in = i[0];
      repeat (H) @(posedge clk);
      #1 sck_in = 1;
      repeat (H - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    reset = 1;
    pend_vld = 0; echo_pend = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (4) @(posedge clk);
    #1;
    slave_xfer(8'hB7);

    check("exp_rx_empty", exp_rx.size(), 0);
    check("exp_sd_empty", exp_sd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
